led_matrix_scanner: RTL

Drives the 8x8 LED matrix from a double-buffered frame store. The scanner time-multiplexes one row at a time, inserting a blanking interval between rows to suppress ghosting. Control logic writes pixel rows into the back bank, typically in response to debounced button pulses. It then requests a swap, which the scanner applies only at a frame boundary, so no frame is ever shown half-updated.

---
 rtl/led_matrix_pkg.sv | 25 ++
 rtl/led_frame_buffer.sv | 37 +++
 rtl/led_matrix_scanner.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/led_matrix_pkg.sv
// Shared constants and types for the 8x8 LED matrix scanner.
// Provides matrix geometry, the row type, the scan phase and a one-hot helper.
package led_matrix_pkg;

   localparam int ROWS  = 8;
   localparam int COLS  = 8;
   localparam int ROW_W = 3;

   typedef logic [COLS-1:0] row_t;

   typedef enum logic {
      PH_BLANK,
      PH_DRIVE
   } phase_t;

   function automatic row_t row_onehot(
      input logic [ROW_W-1:0] idx
   );
      row_t r;
      r      = '0;
      r[idx] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/led_frame_buffer.sv
// Double-buffered 8x8 pixel store: writes go to the back bank, reads come
// from the front bank. Ports: clk, rst, front_sel, wr_en/wr_row/wr_data, rd_row/rd_data.
module led_frame_buffer
   import led_matrix_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             front_sel,
   input  logic             wr_en,
   input  logic [ROW_W-1:0] wr_row,
   input  logic [COLS-1:0]  wr_data,
   input  logic [ROW_W-1:0] rd_row,
   output logic [COLS-1:0]  rd_data
);

   row_t bank0 [ROWS];
   row_t bank1 [ROWS];

   // front_sel = 0: bank0 is shown, bank1 is written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ROWS; i++) begin
            bank0[i] <= '0;
            bank1[i] <= '0;
         end
      end else if (wr_en) begin
         if (front_sel) begin
            bank0[wr_row] <= wr_data;
         end else begin
            bank1[wr_row] <= wr_data;
         end
      end
   end

   assign rd_data = front_sel ? bank1[rd_row] : bank0[rd_row];

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed 8x8 LED matrix driver with blanking and frame-aligned bank swap.
// Ports: clk, rst, wr_en/wr_row/wr_data (back-bank write), swap_req,
// swap_pending, swap_done, frame_start, row_out, col_out.
module led_matrix_scanner
   import led_matrix_pkg::*;
#(
   parameter int CLK_DIV        = 1024,
   parameter int BLANK_CYCLES   = 16,
   parameter int ROW_ACTIVE_LOW = 0,
   parameter int COL_ACTIVE_LOW = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [ROW_W-1:0] wr_row,
   input  logic [COLS-1:0]  wr_data,
   input  logic             swap_req,
   output logic             swap_pending,
   output logic             swap_done,
   output logic             frame_start,
   output logic [ROWS-1:0]  row_out,
   output logic [COLS-1:0]  col_out
);

   localparam int CNT_W = $clog2(CLK_DIV);

   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
   localparam logic [ROW_W-1:0] ROW_ONE   = ROW_W'(1);

   localparam logic [ROWS-1:0] ROW_INV =
      (ROW_ACTIVE_LOW != 0) ? {ROWS{1'b1}} : {ROWS{1'b0}};
   localparam logic [COLS-1:0] COL_INV =
      (COL_ACTIVE_LOW != 0) ? {COLS{1'b1}} : {COLS{1'b0}};

   logic [CNT_W-1:0] slot_cnt;
   logic [CNT_W-1:0] slot_nxt;
   logic [ROW_W-1:0] row_idx;
   logic [ROW_W-1:0] row_nxt;
   logic             front_sel;
   logic             front_nxt;
   logic             pending;
   logic             pending_nxt;

   logic             slot_last;
   logic             at_boundary;
   logic             do_swap;
   phase_t           phase_nxt;

   logic [COLS-1:0]  rd_data;
   logic [ROWS-1:0]  row_d;
   logic [COLS-1:0]  col_d;
   logic             fs_d;

   logic [ROWS-1:0]  row_q;
   logic [COLS-1:0]  col_q;
   logic             fs_q;

   led_frame_buffer u_fb (
      .clk       (clk),
      .rst       (rst),
      .front_sel (front_sel),
      .wr_en     (wr_en),
      .wr_row    (wr_row),
      .wr_data   (wr_data),
      .rd_row    (row_nxt),
      .rd_data   (rd_data)
   );

   assign slot_last   = (slot_cnt == SLOT_LAST);
   assign at_boundary = slot_last && (row_idx == ROW_LAST);
   assign do_swap     = at_boundary && (pending || swap_req);

   always_comb begin
      slot_nxt    = slot_cnt + CNT_ONE;
      row_nxt     = row_idx;
      front_nxt   = front_sel;
      pending_nxt = pending | swap_req;
      if (slot_last) begin
         slot_nxt = '0;
         row_nxt  = row_idx + ROW_ONE;
      end
      // A boundary either consumes the request or leaves nothing pending.
      if (at_boundary) begin
         pending_nxt = 1'b0;
      end
      if (do_swap) begin
         front_nxt = ~front_sel;
      end
   end

   assign phase_nxt = (slot_nxt < BLANK_END) ? PH_BLANK : PH_DRIVE;

   // Outputs are decoded from the next state so the registers match the
   // state of the cycle they are shown in. The front bank is read with the
   // current front_sel: it only flips into a slot-0 cycle, which is blank.
   always_comb begin
      row_d = '0;
      col_d = '0;
      unique case (phase_nxt)
         PH_BLANK: begin
            row_d = '0;
            col_d = '0;
         end
         PH_DRIVE: begin
            row_d = row_onehot(row_nxt);
            col_d = rd_data;
         end
      endcase
   end

   assign fs_d = (slot_nxt == '0) && (row_nxt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_cnt  <= '0;
         row_idx   <= '0;
         front_sel <= 1'b0;
         pending   <= 1'b0;
         row_q     <= '0;
         col_q     <= '0;
         fs_q      <= 1'b0;
      end else begin
         slot_cnt  <= slot_nxt;
         row_idx   <= row_nxt;
         front_sel <= front_nxt;
         pending   <= pending_nxt;
         row_q     <= row_d;
         col_q     <= col_d;
         fs_q      <= fs_d;
      end
   end

   // swap_done must coincide with the boundary cycle even when the request
   // arrives in that same cycle, so it is decoded from state and swap_req.
   assign swap_done    = do_swap;
   assign swap_pending = pending;
   assign frame_start  = fs_q;
   assign row_out      = row_q ^ ROW_INV;
   assign col_out      = col_q ^ COL_INV;

endmodule
